// File: rtl/mips_prog_loader.sv
// Boot loader: frames a big-endian byte stream (count, base, words) into word writes to the
// pipeline's unified memory, then pulses cpu_start to release the core.
module mips_prog_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_start
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_CNT,
        S_HDR_BASE,
        S_DATA,
        S_FIN
    } state_t;

    localparam logic [CNT_W:0] MEM_WORDS = (CNT_W+1)'(2**ADDR_W);

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [7:0]          hi_q, hi_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [23:0]         acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                start_q, start_d;

    logic                hs;
    logic [ADDR_W-1:0]   base_w;
    logic [CNT_W:0]      end_w;
    logic                ovf_now;

    // Overflow is judged on the truncated base with one extra bit so the sum cannot wrap.
    always_comb begin
        base_w  = ADDR_W'({hi_q, in_data});
        end_w   = (CNT_W+1)'(base_w) + (CNT_W+1)'(cnt_q);
        ovf_now = (end_w > MEM_WORDS);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        err_d    = err_q;
        start_d  = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        hs       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_HDR_CNT;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end

            S_HDR_CNT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                hs       = in_valid;
                if (hs) begin
                    if (idx_q == 2'd0) begin
                        hi_d  = in_data;
                        idx_d = 2'd1;
                    end else begin
                        cnt_d   = CNT_W'({hi_q, in_data});
                        idx_d   = '0;
                        state_d = S_HDR_BASE;
                    end
                end
            end

            S_HDR_BASE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                hs       = in_valid;
                if (hs) begin
                    if (idx_q == 2'd0) begin
                        hi_d  = in_data;
                        idx_d = 2'd1;
                    end else begin
                        ptr_d   = base_w;
                        ovf_d   = ovf_now;
                        err_d   = ovf_now;
                        idx_d   = '0;
                        state_d = (cnt_q == '0) ? S_FIN : S_DATA;
                    end
                end
            end

            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                hs       = in_valid;
                if (hs) begin
                    if (idx_q != 2'd3) begin
                        acc_d = {acc_q[15:0], in_data};
                        idx_d = idx_q + 2'd1;
                    end else begin
                        // Overflowed frames are drained to keep the stream aligned, but never written.
                        if (!ovf_q) begin
                            we_d    = 1'b1;
                            addr_d  = ptr_q;
                            wdata_d = {acc_q, in_data};
                            ptr_d   = ptr_q + ADDR_W'(1);
                        end
                        idx_d = '0;
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = S_FIN;
                        end
                    end
                end
            end

            S_FIN: begin
                done_d  = !ovf_q;
                err_d   = ovf_q;
                start_d = !ovf_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign error     = err_q;
    assign cpu_start = start_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: frames are streamed byte by byte and the captured
// memory writes, status levels and start pulse are compared against hand-computed values.
module tb_mips_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_start;

    mips_prog_loader #(.ADDR_W(10), .CNT_W(16)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_start  (cpu_start)
    );

    always #5 clk1 = ~clk1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] img [0:15];
    logic [31:0] fact [0:10];

    // Monitor: owns all capture state; cleared on request from the stimulus block.
    logic        clr = 1'b0;
    logic [9:0]  wa [$];
    logic [31:0] wd [$];
    int          start_cnt, hs_cnt, rdy_drop, cyc;
    int          last_hs_cyc, last_we_cyc, start_cyc;

    always @(negedge clk1) begin
        cyc = cyc + 1;
        if (clr) begin
            wa.delete();
            wd.delete();
            start_cnt = 0;
            hs_cnt = 0;
            rdy_drop = 0;
            last_hs_cyc = 0;
            last_we_cyc = 0;
            start_cyc = 0;
        end else begin
            if (in_valid && in_ready) begin
                hs_cnt = hs_cnt + 1;
                last_hs_cyc = cyc;
            end
            if (mem_we) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
                last_we_cyc = cyc;
            end
            if (cpu_start) begin
                start_cnt = start_cnt + 1;
                start_cyc = cyc;
            end
            if (busy && !in_ready) rdy_drop = rdy_drop + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        clr = 1'b1;
        @(negedge clk1);
        #1 clr = 1'b0;
        @(posedge clk1);
        #1;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        @(posedge clk1);
        #1 load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int unsigned t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk1);
        while (!in_ready && t < 20) begin
            @(negedge clk1);
            t++;
        end
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk1);
        #1 in_valid = 1'b0;
        if (gap) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic send_header(input int unsigned cnt, input int unsigned base, input bit gap);
        logic [15:0] c16, b16;
        c16 = cnt[15:0];
        b16 = base[15:0];
        send_byte(c16[15:8], gap);
        send_byte(c16[7:0], gap);
        send_byte(b16[15:8], gap);
        send_byte(b16[7:0], gap);
    endtask

    // ls_at: data-byte index at which load_start is raised alongside the byte (-1 = never).
    task automatic send_words(input int unsigned cnt, input bit gap, input int ls_at, input int max_bytes);
        logic [31:0] w;
        int          n;
        n = 0;
        for (int unsigned i = 0; i < cnt; i++) begin
            w = img[i];
            for (int unsigned k = 0; k < 4; k++) begin
                if (n < max_bytes) begin
                    if (n == ls_at) load_start = 1'b1;
                    send_byte(w[31 - 8*k -: 8], gap);
                    load_start = 1'b0;
                    n++;
                end
            end
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic check_writes(input string tag, input int unsigned n, input int unsigned base);
        check({tag, "_nwrites"}, wa.size(), n);
        for (int unsigned i = 0; i < n && i < wa.size(); i++) begin
            check({tag, "_addr"}, {22'd0, wa[i]}, base + i);
            check({tag, "_data"}, wd[i], img[i]);
        end
    endtask

    initial begin
        fact[0] = 32'h280a00c8; fact[1] = 32'h28020001; fact[2]  = 32'h0e94a000;
        fact[3] = 32'h21430000; fact[4] = 32'h0e94a000; fact[5]  = 32'h14431000;
        fact[6] = 32'h2c630001; fact[7] = 32'h0e94a000; fact[8]  = 32'h3460fffc;
        fact[9] = 32'h2542fffe; fact[10] = 32'hdc000000;

        // Reset state
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we",   {31'd0, mem_we}, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_done",     {31'd0, done}, 32'd0);
        check("rst_error",    {31'd0, error}, 32'd0);
        check("rst_cpu_start",{31'd0, cpu_start}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk1);
        #1 rst = 1'b0;

        // 1: factorial program, continuous stream
        for (int unsigned i = 0; i < 11; i++) img[i] = fact[i];
        clear_logs();
        pulse_load();
        @(negedge clk1);
        check("t1_busy_after_load", {31'd0, busy}, 32'd1);
        @(posedge clk1);
        #1;
        send_header(11, 0, 1'b0);
        send_words(11, 1'b0, -1, 1000);
        settle();
        check_writes("t1", 11, 0);
        check("t1_start_cnt", start_cnt, 1);
        check("t1_we_latency", last_we_cyc - last_hs_cyc, 1);
        check("t1_start_latency", start_cyc - last_hs_cyc, 2);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_error", {31'd0, error}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_hs", hs_cnt, 48);

        // 2: data word Mem[200] = 7
        img[0] = 32'd7;
        clear_logs();
        pulse_load();
        send_header(1, 200, 1'b0);
        send_words(1, 1'b0, -1, 1000);
        settle();
        check_writes("t2", 1, 200);
        check("t2_start_cnt", start_cnt, 1);
        check("t2_done", {31'd0, done}, 32'd1);

        // 3: factorial frame with in_valid toggling
        for (int unsigned i = 0; i < 11; i++) img[i] = fact[i];
        clear_logs();
        pulse_load();
        send_header(11, 0, 1'b1);
        send_words(11, 1'b1, -1, 1000);
        settle();
        check_writes("t3", 11, 0);
        check("t3_rdy_drop", rdy_drop, 0);
        check("t3_start_cnt", start_cnt, 1);
        check("t3_hs", hs_cnt, 48);
        check("t3_done", {31'd0, done}, 32'd1);

        // 4a: overflow, 1022 + 4 > 1024
        for (int unsigned i = 0; i < 4; i++) img[i] = 32'hA5A50000 + i;
        clear_logs();
        pulse_load();
        send_header(4, 1022, 1'b0);
        @(negedge clk1);
        check("t4_err_after_hdr", {31'd0, error}, 32'd1);
        check("t4_done_after_hdr", {31'd0, done}, 32'd0);
        @(posedge clk1);
        #1;
        send_words(4, 1'b0, -1, 1000);
        settle();
        check("t4_nwrites", wa.size(), 0);
        check("t4_hs", hs_cnt, 20);
        check("t4_error", {31'd0, error}, 32'd1);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_start_cnt", start_cnt, 0);

        // 4b: exact fit, 1022 + 2 == 1024
        clear_logs();
        pulse_load();
        send_header(2, 1022, 1'b0);
        send_words(2, 1'b0, -1, 1000);
        settle();
        check_writes("t4b", 2, 1022);
        check("t4b_error", {31'd0, error}, 32'd0);
        check("t4b_done", {31'd0, done}, 32'd1);
        check("t4b_start_cnt", start_cnt, 1);

        // 5: empty frame
        clear_logs();
        pulse_load();
        send_header(0, 5, 1'b0);
        settle();
        check("t5_nwrites", wa.size(), 0);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_start_cnt", start_cnt, 1);
        check("t5_hs", hs_cnt, 4);

        // 6: reset after 2 bytes of the third word
        for (int unsigned i = 0; i < 4; i++) img[i] = 32'h11223344 * (i + 1);
        clear_logs();
        pulse_load();
        send_header(4, 0, 1'b0);
        send_words(4, 1'b0, -1, 10);
        rst = 1'b1;
        @(posedge clk1);
        #1;
        @(negedge clk1);
        check("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("t6_rst_busy",     {31'd0, busy}, 32'd0);
        check("t6_rst_mem_we",   {31'd0, mem_we}, 32'd0);
        check("t6_rst_done",     {31'd0, done}, 32'd0);
        check("t6_rst_addr",     {22'd0, mem_addr}, 32'd0);
        check("t6_rst_wdata",    mem_wdata, 32'd0);
        @(posedge clk1);
        #1 rst = 1'b0;
        settle();
        check_writes("t6_partial", 2, 0);
        check("t6_start_cnt", start_cnt, 0);

        // 6b: fresh frame with a stray load_start in the middle
        clear_logs();
        pulse_load();
        send_header(4, 0, 1'b0);
        send_words(4, 1'b0, 6, 1000);
        settle();
        check_writes("t6b", 4, 0);
        check("t6b_start_cnt", start_cnt, 1);
        check("t6b_done", {31'd0, done}, 32'd1);
        check("t6b_hs", hs_cnt, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
